// File: rtl/reg_wb_arbiter.sv
// Writeback arbiter: picks one of load/ALU/fetch writes per cycle and registers it
// toward the register file, with anti-starvation aging for the fetch channel.
module reg_wb_arbiter #(
   parameter int unsigned STARVE_MAX = 4,
   parameter logic [3:0]  R_MEM      = 4'hE,
   parameter logic [3:0]  R_ZR       = 4'hF
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_hold,
   input  logic        i_ld_valid,
   output logic        o_ld_ready,
   input  logic [3:0]  i_ld_addr,
   input  logic [15:0] i_ld_data,
   input  logic        i_alu_valid,
   output logic        o_alu_ready,
   input  logic [3:0]  i_alu_addr,
   input  logic [15:0] i_alu_data,
   input  logic        i_fe_valid,
   output logic        o_fe_ready,
   input  logic [3:0]  i_fe_addr,
   input  logic [15:0] i_fe_data,
   output logic        o_wr_en,
   output logic [3:0]  o_dest_addr,
   output logic [15:0] o_dest_data,
   output logic [15:0] o_busy,
   output logic        o_drop,
   output logic [3:0]  o_fe_age
);

   localparam logic [3:0] StarveLim = 4'(STARVE_MAX);

   logic        ld_rdy, alu_rdy, fe_rdy, xfer, discard;
   logic [3:0]  sel_addr;
   logic [15:0] sel_data;

   logic [3:0]  age_q, age_d;
   logic        wr_en_q, wr_en_d;
   logic        drop_q, drop_d;
   logic [3:0]  addr_q, addr_d;
   logic [15:0] data_q, data_d;

   always_comb begin
      ld_rdy  = 1'b0;
      alu_rdy = 1'b0;
      fe_rdy  = 1'b0;
      if (!i_rst && !i_hold) begin
         if (i_fe_valid && (age_q >= StarveLim)) begin
            fe_rdy = 1'b1;
         end else if (i_ld_valid) begin
            ld_rdy = 1'b1;
         end else if (i_alu_valid) begin
            alu_rdy = 1'b1;
         end else if (i_fe_valid) begin
            fe_rdy = 1'b1;
         end
      end
      xfer = ld_rdy | alu_rdy | fe_rdy;

      sel_addr = i_ld_addr;
      sel_data = i_ld_data;
      if (alu_rdy) begin
         sel_addr = i_alu_addr;
         sel_data = i_alu_data;
      end else if (fe_rdy) begin
         sel_addr = i_fe_addr;
         sel_data = i_fe_data;
      end
      // Writes to the memory-mapped and hardwired-zero registers are swallowed.
      discard = (sel_addr == R_MEM) || (sel_addr == R_ZR);

      if (i_rst || !i_fe_valid || fe_rdy) begin
         age_d = 4'd0;
      end else if (age_q != 4'hF) begin
         age_d = age_q + 4'd1;
      end else begin
         age_d = age_q;
      end

      wr_en_d = xfer && !discard;
      drop_d  = xfer && discard;
      addr_d  = xfer ? sel_addr : addr_q;
      data_d  = xfer ? sel_data : data_q;
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         age_q   <= 4'd0;
         wr_en_q <= 1'b0;
         drop_q  <= 1'b0;
         addr_q  <= 4'd0;
         data_q  <= 16'h0000;
      end else begin
         age_q   <= age_d;
         wr_en_q <= wr_en_d;
         drop_q  <= drop_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
      end
   end

   // Reset arriving in the commit cycle cancels the pending write.
   assign o_wr_en     = wr_en_q & ~i_rst;
   assign o_drop      = drop_q & ~i_rst;
   assign o_dest_addr = addr_q;
   assign o_dest_data = data_q;
   assign o_fe_age    = age_q;
   assign o_ld_ready  = ld_rdy;
   assign o_alu_ready = alu_rdy;
   assign o_fe_ready  = fe_rdy;

   always_comb begin
      o_busy = 16'h0000;
      for (int k = 0; k < 16; k++) begin
         o_busy[k] = (o_wr_en && (o_dest_addr == 4'(k)))
                   || (i_ld_valid && (i_ld_addr == 4'(k)))
                   || (i_alu_valid && (i_alu_addr == 4'(k)))
                   || (i_fe_valid && (i_fe_addr == 4'(k)));
      end
      o_busy[R_MEM] = 1'b0;
      o_busy[R_ZR]  = 1'b0;
   end

endmodule
